ccd_timing_calc: RTL and testbench
==================================

CCD_TIMING_CALC -- requirements
Module: ccd_timing_calc

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  FRAME_WD, 16, line-count width
  EXP_WD, 32, pixel-clock-count width
  LINE_PIX, 1560, pixel clocks per line
  BLANK_SHIFT, 3, blank-count multiplier as log2 (x8)
  HEAD_OFS, 6, lines added to the head-blank end
  HEAD_SUB, 8, XSG plus dummy lines excluded from the head-blank count
  XSG_LINES, 4, minimum lines between exposure end and frame end
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; ports, one per line (name  direction  width  meaning):
  clk  in  1  clock
  reset  in  1  synchronous reset, active high
  i_reg_active  in  1  single-cycle request to take a new register set
  i_immediate  in  1  1 = commit without waiting for a frame boundary
  i_frame_boundary  in  1  single-cycle frame-start strobe
  iv_frame_period  in  FRAME_WD  requested frame period, lines
  iv_headblank_end  in  FRAME_WD  head-blank end line
  iv_vref_start  in  FRAME_WD  ROI start line
  iv_tailblank_start  in  FRAME_WD  tail-blank start line
  iv_tailblank_end  in  FRAME_WD  tail-blank end line
  iv_exp_line  in  FRAME_WD  exposure length, lines
  iv_exp_reg  in  EXP_WD  exposure length, pixel clocks
  ov_frame_period  out  FRAME_WD  effective frame period
  ov_headblank_end  out  FRAME_WD  iv_headblank_end+HEAD_OFS
  ov_vref_start  out  FRAME_WD  ROI start
  ov_tailblank_start  out  FRAME_WD  tail-blank start
  ov_tailblank_end  out  FRAME_WD  tail-blank end
  ov_headblank_num  out  FRAME_WD+BLANK_SHIFT  head fast-dump clocks
  ov_tailblank_num  out  FRAME_WD+BLANK_SHIFT  tail fast-dump clocks
  ov_exp_start_reg  out  FRAME_WD  exposure start line
  ov_exp_line_reg  out  EXP_WD  whole-line exposure, pixel clocks
  ov_exp_reg  out  EXP_WD  exposure, pixel clocks
  ov_exp_xsg_reg  out  EXP_WD  fractional exposure, pixel clocks
  o_busy  out  1  high in any state other than IDLE
  o_update_pulse  out  1  one cycle, high in the first cycle new outputs are visible

Function
REQ-003 FSM states SHALL be IDLE, CALC, DERIVE, PEND and COMMIT; i_reg_active sampled high in any state SHALL latch all iv_* into staging and enter CALC with the bit counter cleared.
REQ-004 CALC SHALL compute iv_exp_line*LINE_PIX by shift-add, one multiplier bit per cycle, for exactly FRAME_WD cycles, then enter DERIVE for 1 cycle.
REQ-005 DERIVE SHALL load pending registers with:
  - fp = max(exp_line+XSG_LINES, frame_period), computed at FRAME_WD+1 bits and saturated to all-ones
  - exp_start = fp-exp_line
  - headblank_end = hb+HEAD_OFS
  - headblank_num = (hb+HEAD_OFS-HEAD_SUB)<<BLANK_SHIFT, or 0 if hb+HEAD_OFS<HEAD_SUB
  - tailblank_num = (te-ts)<<BLANK_SHIFT, or 0 if te<ts
  - exp_line_reg = product saturated to EXP_WD
  - exp_xsg = exp_reg-exp_line_reg, or 0 if exp_reg<exp_line_reg
REQ-006 After DERIVE the FSM SHALL enter COMMIT if staged i_immediate=1, else PEND; PEND SHALL hold until i_frame_boundary, then enter COMMIT.
REQ-007 COMMIT SHALL last 1 cycle, copy all pending registers to the outputs and assert o_update_pulse with them, then return to IDLE.
REQ-008 Latency SHALL be FRAME_WD+3 cycles from the i_reg_active cycle to o_update_pulse when immediate.
REQ-009 i_reg_active in CALC or DERIVE SHALL discard the in-flight set and restart.
REQ-010 i_reg_active in PEND without a boundary SHALL replace the pending set.
REQ-011 i_reg_active and i_frame_boundary in the same PEND cycle SHALL commit the old pending set to the outputs with o_update_pulse, latch the new request and enter CALC.
REQ-012 i_frame_boundary outside PEND SHALL be ignored.
REQ-013 Outputs SHALL change only on an o_update_pulse cycle or on reset.

Reset
REQ-014 Reset SHALL force IDLE, o_busy=0 and o_update_pulse=0, load every ov_* with its package default (xsg default = exposure default - line default; num defaults 0), and discard any pending set.

Structure
REQ-015 The default values, FSM state encoding and the blank-count width function SHALL live in shared package ccd_timing_pkg.
REQ-016 The shift-add multiplier SHALL be one sub-module, ccd_seq_mult, with start, done and saturating product.

Verification (FRAME_WD=16, LINE_PIX=1560)
REQ-017 Immediate; exp_line=100, fp=1000, hb=10, ts=900, te=960, exp_reg=200000 -> at cycle 19: fp 1000, exp_start 900, line_reg 156000, xsg 44000, hb_end 16, hb_num 64, tb_num 480.
REQ-018 exp_line=1000, fp=1000 -> ov_frame_period 1004, ov_exp_start_reg 4.
REQ-019 Deferred; boundary at cycle 40 -> outputs unchanged and o_busy=1 through cycle 40; update and pulse at cycle 41.
REQ-020 Second request at cycle 5 -> exactly one pulse, at cycle 24, carrying only the second set.
REQ-021 hb=0, te<ts, exp_reg=1000 with exp_line=100 -> hb_num 0, tb_num 0, xsg 0.
REQ-022 Reset while in PEND -> defaults and o_busy=0; a later boundary causes no update.

Source files
------------

// File: rtl/ccd_timing_pkg.sv
// CCD timing calculator shared definitions.
// Defaults, FSM encoding and blank-count width helper.
package ccd_timing_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DERIVE,
        PEND,
        COMMIT
    } state_t;

    localparam int DEF_FRAME_PERIOD    = 1100;
    localparam int DEF_HEADBLANK_END   = 16;
    localparam int DEF_VREF_START      = 20;
    localparam int DEF_TAILBLANK_START = 1050;
    localparam int DEF_TAILBLANK_END   = 1080;
    localparam int DEF_EXP_START       = 1000;
    localparam int DEF_EXP_LINE_REG    = 156000;
    localparam int DEF_EXP_REG         = 160000;
    localparam int DEF_EXP_XSG         = DEF_EXP_REG - DEF_EXP_LINE_REG;

    function automatic int blank_wd(input int frame_wd, input int shift);
        return frame_wd + shift;
    endfunction

endpackage

// File: rtl/ccd_timing_calc_if.sv
// Register-set request and timing-result bundle.
// master drives requests, slave computes and returns results.
interface ccd_timing_calc_if #(
    parameter int FRAME_WD    = 16,
    parameter int EXP_WD      = 32,
    parameter int BLANK_SHIFT = 3
);
    import ccd_timing_pkg::*;

    localparam int BW = blank_wd(FRAME_WD, BLANK_SHIFT);

    logic                i_reg_active;
    logic                i_immediate;
    logic                i_frame_boundary;
    logic [FRAME_WD-1:0] iv_frame_period;
    logic [FRAME_WD-1:0] iv_headblank_end;
    logic [FRAME_WD-1:0] iv_vref_start;
    logic [FRAME_WD-1:0] iv_tailblank_start;
    logic [FRAME_WD-1:0] iv_tailblank_end;
    logic [FRAME_WD-1:0] iv_exp_line;
    logic [EXP_WD-1:0]   iv_exp_reg;

    logic [FRAME_WD-1:0] ov_frame_period;
    logic [FRAME_WD-1:0] ov_headblank_end;
    logic [FRAME_WD-1:0] ov_vref_start;
    logic [FRAME_WD-1:0] ov_tailblank_start;
    logic [FRAME_WD-1:0] ov_tailblank_end;
    logic [BW-1:0]       ov_headblank_num;
    logic [BW-1:0]       ov_tailblank_num;
    logic [FRAME_WD-1:0] ov_exp_start_reg;
    logic [EXP_WD-1:0]   ov_exp_line_reg;
    logic [EXP_WD-1:0]   ov_exp_reg;
    logic [EXP_WD-1:0]   ov_exp_xsg_reg;
    logic                o_busy;
    logic                o_update_pulse;

    modport master (
        output i_reg_active, i_immediate, i_frame_boundary,
        output iv_frame_period, iv_headblank_end, iv_vref_start,
        output iv_tailblank_start, iv_tailblank_end,
        output iv_exp_line, iv_exp_reg,
        input  ov_frame_period, ov_headblank_end, ov_vref_start,
        input  ov_tailblank_start, ov_tailblank_end,
        input  ov_headblank_num, ov_tailblank_num,
        input  ov_exp_start_reg, ov_exp_line_reg,
        input  ov_exp_reg, ov_exp_xsg_reg,
        input  o_busy, o_update_pulse
    );

    modport slave (
        input  i_reg_active, i_immediate, i_frame_boundary,
        input  iv_frame_period, iv_headblank_end, iv_vref_start,
        input  iv_tailblank_start, iv_tailblank_end,
        input  iv_exp_line, iv_exp_reg,
        output ov_frame_period, ov_headblank_end, ov_vref_start,
        output ov_tailblank_start, ov_tailblank_end,
        output ov_headblank_num, ov_tailblank_num,
        output ov_exp_start_reg, ov_exp_line_reg,
        output ov_exp_reg, ov_exp_xsg_reg,
        output o_busy, o_update_pulse
    );

endinterface

// File: rtl/ccd_seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// done is high in the final accumulation cycle; product is valid after it.
module ccd_seq_mult #(
    parameter int A_WD  = 16,
    parameter int B_WD  = 32,
    parameter int MCAND = 1560,
    parameter int P_WD  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [A_WD-1:0] a,
    output logic            done,
    output logic [P_WD-1:0] product
);

    localparam int AW = A_WD + B_WD;
    localparam int CW = $clog2(A_WD);

    logic [A_WD-1:0] mplier;
    logic [AW-1:0]   mcand;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            run;

    assign done    = run && (cnt == CW'(A_WD - 1));
    assign product = (|acc[AW-1:P_WD]) ? '1 : acc[P_WD-1:0];

    // Restartable accumulate loop; start always wins over a run in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            run    <= 1'b0;
            acc    <= '0;
            mplier <= '0;
            mcand  <= '0;
            cnt    <= '0;
        end else if (start) begin
            run    <= 1'b1;
            acc    <= '0;
            mplier <= a;
            mcand  <= {{A_WD{1'b0}}, B_WD'(MCAND)};
            cnt    <= '0;
        end else if (run) begin
            if (mplier[0]) acc <= acc + mcand;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/ccd_timing_calc.sv
// CCD vertical timing calculator with frame-synchronous register commit.
// Stages a register set, derives timing values, then publishes them atomically.
module ccd_timing_calc
    import ccd_timing_pkg::*;
#(
    parameter int FRAME_WD    = 16,
    parameter int EXP_WD      = 32,
    parameter int LINE_PIX    = 1560,
    parameter int BLANK_SHIFT = 3,
    parameter int HEAD_OFS    = 6,
    parameter int HEAD_SUB    = 8,
    parameter int XSG_LINES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    ccd_timing_calc_if.slave bus
);

    localparam int BW = blank_wd(FRAME_WD, BLANK_SHIFT);
    localparam int FW = FRAME_WD;

    state_t state;
    logic   pulse;
    logic   commit;

    logic          m_done;
    logic [EXP_WD-1:0] m_prod;

    logic [FW-1:0]     stg_fp, stg_hb, stg_vref, stg_ts, stg_te, stg_el;
    logic [EXP_WD-1:0] stg_er;
    logic              stg_imm;

    logic [FW-1:0]     p_fp, p_hbe, p_vref, p_ts, p_te, p_start;
    logic [BW-1:0]     p_hbn, p_tbn;
    logic [EXP_WD-1:0] p_lr, p_er, p_xsg;

    logic [FW-1:0]     r_fp, r_hbe, r_vref, r_ts, r_te, r_start;
    logic [BW-1:0]     r_hbn, r_tbn;
    logic [EXP_WD-1:0] r_lr, r_er, r_xsg;

    logic [FW:0]       d_sum, d_fpx, d_hb6;
    logic [FW-1:0]     d_fp, d_start, d_hbd, d_tbd;
    logic [BW-1:0]     d_hbn, d_tbn;
    logic [EXP_WD-1:0] d_xsg;

    ccd_seq_mult #(
        .A_WD  (FRAME_WD),
        .B_WD  (EXP_WD),
        .MCAND (LINE_PIX),
        .P_WD  (EXP_WD)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.i_reg_active),
        .a       (bus.iv_exp_line),
        .done    (m_done),
        .product (m_prod)
    );

    assign commit = (state == COMMIT) ||
                    ((state == PEND) && bus.i_frame_boundary);

    // Derived timing values from the staged set and the finished product.
    always_comb begin
        d_sum   = {1'b0, stg_el} + (FW+1)'(XSG_LINES);
        d_fpx   = (d_sum > {1'b0, stg_fp}) ? d_sum : {1'b0, stg_fp};
        d_fp    = d_fpx[FW] ? '1 : d_fpx[FW-1:0];
        d_start = d_fp - stg_el;
        d_hb6   = {1'b0, stg_hb} + (FW+1)'(HEAD_OFS);
        d_hbd   = d_hb6[FW-1:0] - FW'(HEAD_SUB);
        d_hbn   = (d_hb6 < (FW+1)'(HEAD_SUB)) ? '0
                : {d_hbd, {BLANK_SHIFT{1'b0}}};
        d_tbd   = stg_te - stg_ts;
        d_tbn   = (stg_te < stg_ts) ? '0
                : {d_tbd, {BLANK_SHIFT{1'b0}}};
        d_xsg   = (stg_er < m_prod) ? '0 : stg_er - m_prod;
    end

    // Staging on request, pending set captured in DERIVE.
    always_ff @(posedge clk) begin
        if (bus.i_reg_active) begin
            stg_fp   <= bus.iv_frame_period;
            stg_hb   <= bus.iv_headblank_end;
            stg_vref <= bus.iv_vref_start;
            stg_ts   <= bus.iv_tailblank_start;
            stg_te   <= bus.iv_tailblank_end;
            stg_el   <= bus.iv_exp_line;
            stg_er   <= bus.iv_exp_reg;
            stg_imm  <= bus.i_immediate;
        end
        if (state == DERIVE) begin
            p_fp    <= d_fp;
            p_start <= d_start;
            p_hbe   <= d_hb6[FW-1:0];
            p_vref  <= stg_vref;
            p_ts    <= stg_ts;
            p_te    <= stg_te;
            p_hbn   <= d_hbn;
            p_tbn   <= d_tbn;
            p_lr    <= m_prod;
            p_er    <= stg_er;
            p_xsg   <= d_xsg;
        end
    end

    // Control FSM with registered outputs; a new request always restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pulse   <= 1'b0;
            r_fp    <= FW'(DEF_FRAME_PERIOD);
            r_hbe   <= FW'(DEF_HEADBLANK_END);
            r_vref  <= FW'(DEF_VREF_START);
            r_ts    <= FW'(DEF_TAILBLANK_START);
            r_te    <= FW'(DEF_TAILBLANK_END);
            r_start <= FW'(DEF_EXP_START);
            r_hbn   <= '0;
            r_tbn   <= '0;
            r_lr    <= EXP_WD'(DEF_EXP_LINE_REG);
            r_er    <= EXP_WD'(DEF_EXP_REG);
            r_xsg   <= EXP_WD'(DEF_EXP_XSG);
        end else begin
            pulse <= commit;
            if (commit) begin
                r_fp    <= p_fp;
                r_hbe   <= p_hbe;
                r_vref  <= p_vref;
                r_ts    <= p_ts;
                r_te    <= p_te;
                r_start <= p_start;
                r_hbn   <= p_hbn;
                r_tbn   <= p_tbn;
                r_lr    <= p_lr;
                r_er    <= p_er;
                r_xsg   <= p_xsg;
            end
            if (bus.i_reg_active) begin
                state <= CALC;
            end else begin
                unique case (state)
                    IDLE:    state <= IDLE;
                    CALC:    if (m_done) state <= DERIVE;
                    DERIVE:  state <= stg_imm ? COMMIT : PEND;
                    PEND:    if (bus.i_frame_boundary) state <= IDLE;
                    COMMIT:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ov_frame_period    = r_fp;
    assign bus.ov_headblank_end   = r_hbe;
    assign bus.ov_vref_start      = r_vref;
    assign bus.ov_tailblank_start = r_ts;
    assign bus.ov_tailblank_end   = r_te;
    assign bus.ov_headblank_num   = r_hbn;
    assign bus.ov_tailblank_num   = r_tbn;
    assign bus.ov_exp_start_reg   = r_start;
    assign bus.ov_exp_line_reg    = r_lr;
    assign bus.ov_exp_reg         = r_er;
    assign bus.ov_exp_xsg_reg     = r_xsg;
    assign bus.o_busy             = (state != IDLE);
    assign bus.o_update_pulse     = pulse;

endmodule

// File: tb/tb_ccd_timing_calc.sv
// Scoreboard bench for ccd_timing_calc.
// Expected sets are queued at stimulus time and checked on o_update_pulse.
module tb_ccd_timing_calc;

    typedef struct {
        logic [15:0] fp, hbe, vref, ts, te, start;
        logic [18:0] hbn, tbn;
        logic [31:0] lr, er, xsg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    exp_t q[$];
    exp_t cur;
    exp_t mon_e;
    exp_t staged;
    logic [229:0] ov_all;

    ccd_timing_calc_if #(.FRAME_WD(16), .EXP_WD(32), .BLANK_SHIFT(3)) bus();

    ccd_timing_calc #(
        .FRAME_WD(16), .EXP_WD(32), .LINE_PIX(1560), .BLANK_SHIFT(3),
        .HEAD_OFS(6), .HEAD_SUB(8), .XSG_LINES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    assign ov_all = {bus.ov_frame_period, bus.ov_headblank_end,
                     bus.ov_vref_start, bus.ov_tailblank_start,
                     bus.ov_tailblank_end, bus.ov_headblank_num,
                     bus.ov_tailblank_num, bus.ov_exp_start_reg,
                     bus.ov_exp_line_reg, bus.ov_exp_reg,
                     bus.ov_exp_xsg_reg};

    function automatic logic [229:0] pack(input exp_t e);
        return {e.fp, e.hbe, e.vref, e.ts, e.te, e.hbn, e.tbn,
                e.start, e.lr, e.er, e.xsg};
    endfunction

    function automatic exp_t defaults();
        exp_t e;
        e.fp = 1100; e.hbe = 16; e.vref = 20; e.ts = 1050; e.te = 1080;
        e.start = 1000; e.hbn = 0; e.tbn = 0;
        e.lr = 156000; e.er = 160000; e.xsg = 4000; e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t model(input int el, fpr, hb, vref, ts, te,
                                   input longint er, input int cyc);
        exp_t e;
        longint fp, lr;
        fp = el + 4;
        if (fpr > fp) fp = fpr;
        if (fp > 65535) fp = 65535;
        e.fp    = 16'(fp);
        e.start = 16'(fp - el);
        e.hbe   = 16'(hb + 6);
        e.vref  = 16'(vref);
        e.ts    = 16'(ts);
        e.te    = 16'(te);
        e.hbn   = (hb + 6 < 8) ? 19'd0 : 19'(((hb + 6 - 8) % 65536) * 8);
        e.tbn   = (te < ts) ? 19'd0 : 19'((te - ts) * 8);
        lr      = longint'(el) * 1560;
        if (lr > 64'hFFFF_FFFF) lr = 64'hFFFF_FFFF;
        e.lr    = 32'(lr);
        e.er    = 32'(er);
        e.xsg   = (er < lr) ? 32'd0 : 32'(er - lr);
        e.cyc   = cyc;
        return e;
    endfunction

    // Scoreboard: compare each published set, and hold between updates.
    always @(negedge clk) begin
        if (bus.o_update_pulse === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at edge %0d", edge_cnt);
            end else begin
                mon_e = q.pop_front();
                checks++; if (edge_cnt != mon_e.cyc) begin errors++; $display("FAIL pulse_cycle got %0d want %0d", edge_cnt, mon_e.cyc); end
                checks++; if (bus.ov_frame_period !== mon_e.fp) begin errors++; $display("FAIL frame_period got %0d want %0d", bus.ov_frame_period, mon_e.fp); end
                checks++; if (bus.ov_exp_start_reg !== mon_e.start) begin errors++; $display("FAIL exp_start got %0d want %0d", bus.ov_exp_start_reg, mon_e.start); end
                checks++; if (bus.ov_headblank_end !== mon_e.hbe) begin errors++; $display("FAIL hb_end got %0d want %0d", bus.ov_headblank_end, mon_e.hbe); end
                checks++; if (bus.ov_vref_start !== mon_e.vref) begin errors++; $display("FAIL vref got %0d want %0d", bus.ov_vref_start, mon_e.vref); end
                checks++; if (bus.ov_tailblank_start !== mon_e.ts) begin errors++; $display("FAIL tb_start got %0d want %0d", bus.ov_tailblank_start, mon_e.ts); end
                checks++; if (bus.ov_tailblank_end !== mon_e.te) begin errors++; $display("FAIL tb_end got %0d want %0d", bus.ov_tailblank_end, mon_e.te); end
                checks++; if (bus.ov_headblank_num !== mon_e.hbn) begin errors++; $display("FAIL hb_num got %0d want %0d", bus.ov_headblank_num, mon_e.hbn); end
                checks++; if (bus.ov_tailblank_num !== mon_e.tbn) begin errors++; $display("FAIL tb_num got %0d want %0d", bus.ov_tailblank_num, mon_e.tbn); end
                checks++; if (bus.ov_exp_line_reg !== mon_e.lr) begin errors++; $display("FAIL line_reg got %0d want %0d", bus.ov_exp_line_reg, mon_e.lr); end
                checks++; if (bus.ov_exp_reg !== mon_e.er) begin errors++; $display("FAIL exp_reg got %0d want %0d", bus.ov_exp_reg, mon_e.er); end
                checks++; if (bus.ov_exp_xsg_reg !== mon_e.xsg) begin errors++; $display("FAIL xsg got %0d want %0d", bus.ov_exp_xsg_reg, mon_e.xsg); end
                cur = mon_e;
            end
        end
        checks++;
        if (ov_all !== pack(cur)) begin
            errors++;
            $display("FAIL hold at edge %0d got %h want %h", edge_cnt, ov_all, pack(cur));
        end
    end

    task automatic req(input int el, fpr, hb, vref, ts, te,
                       input longint er, input bit imm, input bit expect_it);
        staged = model(el, fpr, hb, vref, ts, te, er, edge_cnt + 19);
        if (expect_it) q.push_back(staged);
        bus.iv_exp_line        = 16'(el);
        bus.iv_frame_period    = 16'(fpr);
        bus.iv_headblank_end   = 16'(hb);
        bus.iv_vref_start      = 16'(vref);
        bus.iv_tailblank_start = 16'(ts);
        bus.iv_tailblank_end   = 16'(te);
        bus.iv_exp_reg         = 32'(er);
        bus.i_immediate        = imm;
        bus.i_reg_active       = 1'b1;
        @(negedge clk);
        bus.i_reg_active       = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d", q.size());
            q.delete();
        end
    endtask

    task automatic boundary();
        staged.cyc = edge_cnt + 1;
        q.push_back(staged);
        bus.i_frame_boundary = 1'b1;
        @(negedge clk);
        bus.i_frame_boundary = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_update_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got %b want 0", bus.o_update_pulse); end
        checks++; if (bus.ov_frame_period !== 16'd1100) begin errors++; $display("FAIL rst_fp got %0d want 1100", bus.ov_frame_period); end
        checks++; if (bus.ov_exp_xsg_reg !== 32'd4000) begin errors++; $display("FAIL rst_xsg got %0d want 4000", bus.ov_exp_xsg_reg); end
        checks++; if (bus.ov_headblank_num !== 19'd0) begin errors++; $display("FAIL rst_hbn got %0d want 0", bus.ov_headblank_num); end
        #1 reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_immediate();
        req(100, 1000, 10, 30, 900, 960, 200000, 1'b1, 1'b1);
        repeat (9) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL imm_busy got %b want 1", bus.o_busy); end
        wait_drain(40);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL imm_idle got %b want 0", bus.o_busy); end
    endtask

    task automatic test_long_exposure();
        req(1000, 1000, 2, 5, 10, 10, 1560000, 1'b1, 1'b1);
        wait_drain(40);
    endtask

    task automatic test_saturation();
        req(65535, 10, 65530, 7, 65535, 0, 64'hFFFF_FFFF, 1'b1, 1'b1);
        wait_drain(40);
    endtask

    task automatic test_clamp();
        req(100, 1000, 0, 12, 960, 900, 1000, 1'b1, 1'b1);
        wait_drain(40);
    endtask

    task automatic test_deferred();
        req(300, 1200, 40, 50, 1000, 1100, 600000, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (bus.o_busy !== 1'b1 || bus.ov_frame_period !== cur.fp) begin
                errors++;
                $display("FAIL defer_hold k=%0d busy %b fp %0d want 1 %0d", k, bus.o_busy, bus.ov_frame_period, cur.fp);
            end
        end
        boundary();
        wait_drain(10);
    endtask

    task automatic test_restart();
        req(200, 500, 20, 9, 400, 450, 100000, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        req(50, 800, 30, 40, 700, 790, 90000, 1'b1, 1'b1);
        wait_drain(40);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_replace_pending();
        req(120, 900, 14, 3, 500, 520, 300000, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        req(80, 700, 22, 11, 600, 640, 130000, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        boundary();
        wait_drain(10);
    endtask

    task automatic test_commit_and_restart();
        exp_t a_set;
        req(150, 600, 12, 4, 300, 310, 250000, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        a_set = staged;
        a_set.cyc = edge_cnt + 1;
        q.push_back(a_set);
        bus.i_frame_boundary = 1'b1;
        req(60, 400, 18, 6, 200, 230, 95000, 1'b1, 1'b1);
        bus.i_frame_boundary = 1'b0;
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL car_busy got %b want 1", bus.o_busy); end
        wait_drain(40);
    endtask

    task automatic test_boundary_ignored();
        bus.i_frame_boundary = 1'b1;
        @(negedge clk);
        bus.i_frame_boundary = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b want 0", bus.o_busy); end
    endtask

    task automatic test_reset_in_pend();
        req(90, 950, 25, 8, 800, 880, 170000, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rip_pend got %b want 1", bus.o_busy); end
        #1;
        reset = 1'b1;
        cur = defaults();
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rip_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.ov_frame_period !== 16'd1100) begin errors++; $display("FAIL rip_fp got %0d want 1100", bus.ov_frame_period); end
        bus.i_frame_boundary = 1'b1;
        @(negedge clk);
        bus.i_frame_boundary = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.o_update_pulse !== 1'b0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL rip_no_update pulse %b busy %b want 0 0", bus.o_update_pulse, bus.o_busy);
            end
        end
    endtask

    initial begin
        cur = defaults();
        bus.i_reg_active       = 1'b0;
        bus.i_immediate        = 1'b0;
        bus.i_frame_boundary   = 1'b0;
        bus.iv_frame_period    = '0;
        bus.iv_headblank_end   = '0;
        bus.iv_vref_start      = '0;
        bus.iv_tailblank_start = '0;
        bus.iv_tailblank_end   = '0;
        bus.iv_exp_line        = '0;
        bus.iv_exp_reg         = '0;
        test_reset();
        test_boundary_ignored();
        test_immediate();
        test_long_exposure();
        test_saturation();
        test_clamp();
        test_deferred();
        test_restart();
        test_replace_pending();
        test_commit_and_restart();
        test_reset_in_pend();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
